// File: rtl/book_request_arbiter_pkg.sv
// book_request_arbiter_pkg: shared order-book field widths, command codes and arbiter state type
package book_request_arbiter_pkg;

    localparam int STOCK_INDEX    = 3;
    localparam int PRICE_INDEX    = 15;
    localparam int ORDER_INDEX    = 7;
    localparam int QUANTITY_INDEX = 7;

    localparam logic [2:0] ADD_ORDER    = 3'd1;
    localparam logic [2:0] CANCEL_ORDER = 3'd2;

    typedef struct packed {
        logic [PRICE_INDEX:0]    price;
        logic [ORDER_INDEX:0]    order_id;
        logic [QUANTITY_INDEX:0] quantity;
    } book_entry;

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT_DONE} arb_state_e;

endpackage

// File: rtl/book_request_arbiter_rr_select.sv
// rr_select: picks the first valid requester at or after ptr, wrapping around
module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    // scan offsets 0..N-1 from ptr; the first hit wins
    always_comb begin
        any   = 1'b0;
        index = '0;
        for (int k = 0; k < N; k++) begin
            automatic int j = (int'(ptr) + k) % N;
            if (!any && valid[j]) begin
                any   = 1'b1;
                index = IW'(j);
            end
        end
        grant = any ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/book_request_arbiter.sv
// book_request_arbiter: round-robin arbitration of requester commands onto a single order book
module book_request_arbiter
    import book_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                                  clk_100mhz,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][STOCK_INDEX:0]     req_stock,
    input  logic [NUM_REQ-1:0][2:0]               req_type,
    input  book_entry [NUM_REQ-1:0]               req_entry,
    input  logic [NUM_REQ-1:0][ORDER_INDEX:0]     req_order_id,
    input  logic [NUM_REQ-1:0][QUANTITY_INDEX:0]  req_quantity,
    input  logic [NUM_REQ-1:0]                    req_delete,
    output logic [STOCK_INDEX:0]                  stock_to_add,
    output book_entry                             entry,
    output logic [2:0]                            request,
    output logic [ORDER_INDEX:0]                  order_id,
    output logic [QUANTITY_INDEX:0]               quantity,
    output logic                                  delete,
    output logic                                  start,
    input  logic                                  book_busy,
    output logic [NUM_REQ-1:0]                    done,
    output logic [NUM_REQ-1:0]                    err,
    output logic                                  arb_busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT) + 1;

    arb_state_e                state_q, state_d;
    logic [IW-1:0]             ptr_q, ptr_d, owner_q, owner_d, sel_idx;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      start_q, start_d, any_valid;
    logic [NUM_REQ-1:0]        grant;
    logic [STOCK_INDEX:0]      stock_q, stock_d;
    book_entry                 entry_q, entry_d;
    logic [2:0]                request_q, request_d;
    logic [ORDER_INDEX:0]      order_id_q, order_id_d;
    logic [QUANTITY_INDEX:0]   quantity_q, quantity_d;
    logic                      delete_q, delete_d;

    rr_select #(.N(NUM_REQ), .IW(IW)) u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .index (sel_idx),
        .any   (any_valid)
    );

    assign stock_to_add = stock_q;
    assign entry        = entry_q;
    assign request      = request_q;
    assign order_id     = order_id_q;
    assign quantity     = quantity_q;
    assign delete       = delete_q;
    assign start        = start_q;
    assign arb_busy     = state_q != IDLE;

    // next-state, grant and completion logic; the book payload is captured only on accept
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        timer_d    = timer_q;
        start_d    = 1'b0;
        stock_d    = stock_q;
        entry_d    = entry_q;
        request_d  = request_q;
        order_id_d = order_id_q;
        quantity_d = quantity_q;
        delete_d   = delete_q;
        req_ready  = '0;
        done       = '0;
        err        = '0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (any_valid) begin
                    state_d    = ISSUE;
                    owner_d    = sel_idx;
                    start_d    = 1'b1;
                    stock_d    = req_stock[sel_idx];
                    entry_d    = req_entry[sel_idx];
                    request_d  = req_type[sel_idx];
                    order_id_d = req_order_id[sel_idx];
                    quantity_d = req_quantity[sel_idx];
                    delete_d   = req_delete[sel_idx];
                end
            end
            ISSUE:  state_d = SETTLE;
            SETTLE: begin
                state_d = WAIT_DONE;
                timer_d = '0;
            end
            WAIT_DONE: begin
                if (!book_busy || timer_q == TW'(TIMEOUT - 1)) begin
                    done[owner_q] = !book_busy;
                    err[owner_q]  = book_busy;
                    ptr_d         = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
                    state_d       = IDLE;
                end else begin
                    timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and book command registers, cleared asynchronously
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            timer_q    <= '0;
            start_q    <= 1'b0;
            stock_q    <= '0;
            entry_q    <= '0;
            request_q  <= '0;
            order_id_q <= '0;
            quantity_q <= '0;
            delete_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            timer_q    <= timer_d;
            start_q    <= start_d;
            stock_q    <= stock_d;
            entry_q    <= entry_d;
            request_q  <= request_d;
            order_id_q <= order_id_d;
            quantity_q <= quantity_d;
            delete_q   <= delete_d;
        end
    end

endmodule

// File: tb/tb_book_request_arbiter.sv
// tb_book_request_arbiter: directed self-checking bench for book_request_arbiter
module tb_book_request_arbiter;
    import book_request_arbiter_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic [3:0]                         req_valid, req_ready, req_delete, done, err;
    logic [3:0][STOCK_INDEX:0]          req_stock;
    logic [3:0][2:0]                    req_type;
    book_entry [3:0]                    req_entry;
    logic [3:0][ORDER_INDEX:0]          req_order_id;
    logic [3:0][QUANTITY_INDEX:0]       req_quantity;
    logic [STOCK_INDEX:0]               stock_to_add;
    book_entry                          entry;
    logic [2:0]                         request;
    logic [ORDER_INDEX:0]               order_id;
    logic [QUANTITY_INDEX:0]            quantity;
    logic                               delete, start, book_busy, arb_busy;
    int n_cmp = 0, n_bad = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;

    always #5 clk = ~clk;

    book_request_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .clk_100mhz   (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_stock    (req_stock),
        .req_type     (req_type),
        .req_entry    (req_entry),
        .req_order_id (req_order_id),
        .req_quantity (req_quantity),
        .req_delete   (req_delete),
        .stock_to_add (stock_to_add),
        .entry        (entry),
        .request      (request),
        .order_id     (order_id),
        .quantity     (quantity),
        .delete       (delete),
        .start        (start),
        .book_busy    (book_busy),
        .done         (done),
        .err          (err),
        .arb_busy     (arb_busy)
    );

    // pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            start_cnt += int'(start);
            done_cnt  += $countones(done);
            err_cnt   += $countones(err);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        start_cnt = 0;
        done_cnt  = 0;
        err_cnt   = 0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req_valid    = '0;
        req_stock    = '0;
        req_type     = '0;
        req_entry    = '0;
        req_order_id = '0;
        req_quantity = '0;
        req_delete   = '0;
        book_busy    = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        clear_counts();
    endtask

    task automatic set_req(input int k, input logic [2:0] t, input logic [3:0] s, input logic [15:0] p,
                           input logic [7:0] eo, input logic [7:0] eq, input logic [7:0] oid,
                           input logic [7:0] q, input logic del);
        req_type[k]     = t;
        req_stock[k]    = s;
        req_entry[k]    = '{price: p, order_id: eo, quantity: eq};
        req_order_id[k] = oid;
        req_quantity[k] = q;
        req_delete[k]   = del;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_rdy [9] = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8};
        logic [3:0] exp_dn  [9] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
        int         order   [5] = '{0, 1, 2, 3, 0};

        // reset state
        do_reset();
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_busy", 64'(arb_busy), 64'h0);
        check("rst_start", 64'(start), 64'h0);
        check("rst_done_err", 64'({done, err}), 64'h0);
        check("rst_entry", 64'(entry), 64'h0);
        check("rst_stock", 64'(stock_to_add), 64'h0);

        // requester 2 alone, book busy for 3 cycles
        set_req(2, ADD_ORDER, 4'd1, 16'h7F00, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("t1_ready", 64'(req_ready), 64'h4);
        cyc();
        req_valid = '0;
        #1;
        check("t1_start", 64'(start), 64'h1);
        check("t1_stock", 64'(stock_to_add), 64'h1);
        check("t1_entry", 64'(entry), 64'h7F001234);
        check("t1_request", 64'(request), 64'(ADD_ORDER));
        cyc();
        book_busy = 1'b1;
        cyc();
        cyc();
        check("t1_no_done_busy", 64'({done, err}), 64'h0);
        cyc();
        book_busy = 1'b0;
        #1;
        check("t1_done", 64'(done), 64'h4);
        check("t1_err", 64'(err), 64'h0);
        cyc();
        check("t1_idle", 64'(arb_busy), 64'h0);
        check("t1_entry_hold", 64'(entry), 64'h7F001234);
        check("t1_start_cnt", 64'(start_cnt), 64'h1);
        check("t1_done_cnt", 64'(done_cnt), 64'h1);
        check("t1_err_cnt", 64'(err_cnt), 64'h0);

        // all four valid: grant order 0,1,2,3,0
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t2_ready%0d", i), 64'(req_ready), 64'(1) << order[i]);
            cyc();
            cyc();
            cyc();
            check($sformatf("t2_done%0d", i), 64'(done), 64'(1) << order[i]);
            cyc();
        end

        // book stuck busy: err on 16th WAIT_DONE cycle, then next requester
        do_reset();
        req_valid = 4'b0110;
        book_busy = 1'b1;
        #1;
        check("t3_ready", 64'(req_ready), 64'h2);
        cyc();
        cyc();
        cyc();
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t3_wait%0d", i), 64'({done, err}), 64'h0);
            cyc();
        end
        check("t3_err", 64'(err), 64'h2);
        check("t3_no_done", 64'(done), 64'h0);
        cyc();
        book_busy = 1'b0;
        #1;
        check("t3_next_ready", 64'(req_ready), 64'h4);
        check("t3_err_cnt", 64'(err_cnt), 64'h1);
        check("t3_done_cnt", 64'(done_cnt), 64'h0);

        // reset during WAIT_DONE
        do_reset();
        set_req(2, ADD_ORDER, 4'd5, 16'h1111, 8'h22, 8'h33, 8'h00, 8'h00, 1'b1);
        req_valid = 4'b0100;
        book_busy = 1'b1;
        cyc();
        cyc();
        cyc();
        cyc();
        check("t4_in_wait", 64'(arb_busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check("t4_busy", 64'(arb_busy), 64'h0);
        check("t4_outs", 64'({start, done, err, delete}), 64'h0);
        check("t4_entry", 64'(entry), 64'h0);
        check("t4_stock", 64'(stock_to_add), 64'h0);
        req_valid = 4'b0101;
        book_busy = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        check("t4_ready", 64'(req_ready), 64'h1);
        check("t4_done_err_cnt", 64'(done_cnt + err_cnt), 64'h0);

        // payload change after accept is ignored
        do_reset();
        set_req(1, CANCEL_ORDER, 4'd0, 16'h0000, 8'h00, 8'h00, 8'h01, 8'h07, 1'b1);
        req_valid = 4'b0010;
        #1;
        check("t5_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid = '0;
        set_req(1, ADD_ORDER, 4'd9, 16'hFFFF, 8'h99, 8'h99, 8'h09, 8'h01, 1'b0);
        #1;
        check("t5_request", 64'(request), 64'(CANCEL_ORDER));
        check("t5_order_id", 64'(order_id), 64'h1);
        check("t5_delete", 64'(delete), 64'h1);
        check("t5_quantity", 64'(quantity), 64'h7);
        cyc();
        cyc();
        check("t5_done", 64'(done), 64'h2);
        check("t5_order_hold", 64'({request, order_id, delete}), 64'({CANCEL_ORDER, 8'h01, 1'b1}));

        // back-to-back on requester 3 with idle book: accepts 4 cycles apart
        do_reset();
        req_valid = 4'b1000;
        for (int i = 0; i < 9; i++) begin
            #1;
            check($sformatf("t6_ready%0d", i), 64'(req_ready), 64'(exp_rdy[i]));
            check($sformatf("t6_done%0d", i), 64'(done), 64'(exp_dn[i]));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
